tmr_scrub_ctrl: RTL and testbench
=================================

// Module: tmr_scrub_ctrl
// PURPOSE
//  Triplicated DataWidth-bit state register with bitwise majority read-out (TMR_voter per bit).
//  Scrub FSM periodically compares replicas to the vote, rewrites all three with the voted
//  value, logs per-replica error counts and flags persistently faulty replicas.
//  Used for configuration/state registers in fault-tolerant clusters.
// PARAMETERS
//  DataWidth      32  width of protected register
//  VoterType      2   passed to every TMR_voter instance (0 classical, 1 KP, 2 BN)
//  ScrubPeriod    16  IDLE cycles between scrubs (>=1)
//  ErrCntWidth    8   width of each per-replica error counter
//  FaultThreshold 4   count value at which fault_o[r] sets (1..2^ErrCntWidth-1)
// PORTS
//  clk_i          in  1              clock
//  rst_ni         in  1              asynchronous active-low reset
//  wr_en_i        in  1              write wr_data_i into all three replicas
//  wr_data_i      in  DataWidth      write data
//  rd_data_o      out DataWidth      bitwise majority of replicas (combinational)
//  scrub_en_i     in  1              enable periodic scrubbing
//  inj_en_i       in  1              fault injection strobe (test/debug)
//  inj_replica_i  in  2              target replica 0..2 (3 = no effect)
//  inj_mask_i     in  DataWidth      XOR mask applied to target replica
//  clr_i          in  1              clear all error counters and fault flags
//  err_o          out 1              1-cycle pulse: scrub found and corrected a mismatch
//  err_replica_o  out 3              mismatching replicas of that scrub (valid with err_o)
//  multi_err_o    out 1              1-cycle pulse with err_o when >=2 replicas mismatched
//  err_cnt_o      out 3*ErrCntWidth  per-replica counters, replica r at [r*ErrCntWidth +: ErrCntWidth]
//  fault_o        out 3              sticky per-replica fault flags
// BEHAVIOUR
//  Reset: replicas=0, rd_data_o=0, counters=0, fault_o=0, err_o/err_replica_o/multi_err_o=0,
//   state IDLE, period counter=ScrubPeriod-1.
//  States: IDLE -> CHECK -> CORRECT -> IDLE.
//  IDLE: if scrub_en_i, period counter decrements; at 0 with scrub_en_i -> CHECK, reload.
//   If scrub_en_i low, counter holds reload value (restarts full period on re-enable).
//  CHECK (1 cycle): mm_q[r] <= (replica r != rd_data_o); -> CORRECT.
//  CORRECT (1 cycle): all replicas <= rd_data_o (vote of this cycle); for each r with mm_q[r],
//   counter r increments, saturating at all-ones; -> IDLE. If mm_q!=0, next cycle err_o=1,
//   err_replica_o=mm_q, multi_err_o=(popcount(mm_q)>=2); all three low/zero otherwise.
//  Scrub latency: first CHECK ScrubPeriod cycles after rst_ni release (scrub_en_i high);
//   err_o 2 cycles after CHECK entry; scrub cycle period = ScrubPeriod+2.
//  scrub_en_i dropping in CHECK/CORRECT does not abort the scrub.
//  Replica write priority per cycle: wr_en_i > CORRECT rewrite > injection (lower ones dropped).
//  wr_en_i in CHECK or CORRECT: abort to IDLE, reload period, no counter update, no err_o.
//  wr_en_i in IDLE does not disturb the period counter.
//  fault_o[r] sets on the cycle counter r becomes >= FaultThreshold; sticky until clr_i.
//  clr_i: counters and fault_o cleared next cycle; wins over same-cycle increment.
//  rd_data_o reflects replica updates the cycle after they are written.
//  Reset assertion mid-scrub: immediate return to reset values, no pulses.
// TESTING
//  1 Reset, scrub_en_i=0 -> all outputs 0; hold 100 cycles -> err_o never pulses.
//  2 Write 0xA5A5A5A5, inject replica 1 mask 0x1, scrub_en_i=1 -> rd_data_o=0xA5A5A5A5
//    throughout; one err_o pulse, err_replica_o=3'b010, multi_err_o=0, cnt1=1; next scrub silent.
//  3 Inject replica 0 mask 0x1 and replica 2 mask 0x2 -> rd_data_o unchanged;
//    err_replica_o=3'b101, multi_err_o=1, cnt0=cnt2=1, replicas repaired.
//  4 Four inject+scrub rounds on replica 2 -> fault_o=3'b100 after 4th CORRECT; stays set
//    after further clean scrubs; clr_i -> fault_o=0, cnt2=0.
//  5 Inject replica 0, then wr_en_i=1 (0x12345678) during CHECK -> no err_o, cnt0=0,
//    rd_data_o=0x12345678, next scrub ScrubPeriod cycles later is clean.
//  6 ErrCntWidth=2, FaultThreshold=3: 5 error scrubs on replica 1 -> cnt1 saturates at 3;
//    clr_i in a CORRECT cycle with mismatch -> cnt1=0 afterwards.

Source files
------------

// File: rtl/tmr_scrub_ctrl.sv
// Triple-modular-redundant state register with periodic scrubbing.
// Three replicas hold the same DataWidth-bit value; the read port is their
// bitwise majority. A small FSM periodically snapshots which replicas disagree
// with the vote, then rewrites all three with the vote. It logs mismatches in
// saturating per-replica counters and raises sticky fault flags for replicas
// that keep failing.

// One-bit majority voter. All variants give the same result; they differ only
// in gate structure and in how a fault inside the voter itself propagates.
module tmr_scrub_voter_bit #(
  parameter int unsigned VoterType = 2
) (
  input  logic [2:0] in_i,
  output logic       out_o
);
  generate
    if (VoterType == 0) begin : g_classic
      assign out_o = (in_i[0] & in_i[1]) | (in_i[0] & in_i[2]) | (in_i[1] & in_i[2]);
    end else if (VoterType == 1) begin : g_kp
      assign out_o = (in_i[0] ^ in_i[1]) ? in_i[2] : in_i[0];
    end else begin : g_bn
      assign out_o = (in_i[1] ^ in_i[2]) ? in_i[0] : in_i[1];
    end
  endgenerate
endmodule

module tmr_scrub_ctrl #(
  parameter int unsigned DataWidth      = 32,
  parameter int unsigned VoterType      = 2,
  parameter int unsigned ScrubPeriod    = 16,
  parameter int unsigned ErrCntWidth    = 8,
  parameter int unsigned FaultThreshold = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     wr_en_i,
  input  logic [DataWidth-1:0]     wr_data_i,
  output logic [DataWidth-1:0]     rd_data_o,
  input  logic                     scrub_en_i,
  input  logic                     inj_en_i,
  input  logic [1:0]               inj_replica_i,
  input  logic [DataWidth-1:0]     inj_mask_i,
  input  logic                     clr_i,
  output logic                     err_o,
  output logic [2:0]               err_replica_o,
  output logic                     multi_err_o,
  output logic [3*ErrCntWidth-1:0] err_cnt_o,
  output logic [2:0]               fault_o
);

  localparam int unsigned PerW = (ScrubPeriod > 1) ? $clog2(ScrubPeriod) : 1;
  localparam logic [PerW-1:0]        PerReload = PerW'(ScrubPeriod - 1);
  localparam logic [ErrCntWidth-1:0] Thr       = ErrCntWidth'(FaultThreshold);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CHECK   = 2'd1,
    ST_CORRECT = 2'd2
  } state_e;

  state_e                           state_q, state_d;
  logic [PerW-1:0]                  per_q, per_d;
  logic [2:0][DataWidth-1:0]        rep_q, rep_d;
  logic [2:0]                       mm_q, mm_d;
  logic [2:0][ErrCntWidth-1:0]      cnt_q, cnt_d;
  logic [2:0]                       fault_q, fault_d;
  logic                             err_q, err_d;
  logic [2:0]                       err_rep_q, err_rep_d;
  logic                             multi_q, multi_d;
  logic [DataWidth-1:0]             vote;
  logic                             do_fix;

  // Per-bit majority across the three replicas.
  generate
    for (genvar b = 0; b < int'(DataWidth); b++) begin : g_vote
      tmr_scrub_voter_bit #(.VoterType(VoterType)) u_vote (
        .in_i  ({rep_q[2][b], rep_q[1][b], rep_q[0][b]}),
        .out_o (vote[b])
      );
    end
  endgenerate

  assign rd_data_o     = vote;
  assign err_o         = err_q;
  assign err_replica_o = err_rep_q;
  assign multi_err_o   = multi_q;
  assign err_cnt_o     = cnt_q;
  assign fault_o       = fault_q;

  // Next-state: scrub sequencing, replica write arbitration, error bookkeeping.
  always_comb begin
    state_d   = state_q;
    per_d     = per_q;
    mm_d      = mm_q;
    rep_d     = rep_q;
    cnt_d     = cnt_q;
    fault_d   = fault_q;
    err_d     = 1'b0;
    err_rep_d = '0;
    multi_d   = 1'b0;
    do_fix    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Disabled scrubbing parks the counter at reload so re-enable
        // starts a full period; host writes leave the countdown alone.
        if (!scrub_en_i) begin
          per_d = PerReload;
        end else if (per_q == '0) begin
          state_d = ST_CHECK;
          per_d   = PerReload;
        end else begin
          per_d = per_q - PerW'(1);
        end
      end
      ST_CHECK: begin
        if (wr_en_i) begin
          // Fresh host data makes the snapshot meaningless: abandon the scrub.
          state_d = ST_IDLE;
          per_d   = PerReload;
        end else begin
          for (int r = 0; r < 3; r++) mm_d[r] = (rep_q[r] != vote);
          state_d = ST_CORRECT;
        end
      end
      ST_CORRECT: begin
        state_d = ST_IDLE;
        per_d   = PerReload;
        if (!wr_en_i) begin
          do_fix    = 1'b1;
          err_d     = |mm_q;
          err_rep_d = mm_q;
          multi_d   = (mm_q[0] & mm_q[1]) | (mm_q[0] & mm_q[2]) | (mm_q[1] & mm_q[2]);
          for (int r = 0; r < 3; r++) begin
            if (mm_q[r] && (cnt_q[r] != '1)) cnt_d[r] = cnt_q[r] + ErrCntWidth'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        per_d   = PerReload;
      end
    endcase

    // Host write beats scrub rewrite beats fault injection.
    if (wr_en_i) begin
      rep_d = {wr_data_i, wr_data_i, wr_data_i};
    end else if (do_fix) begin
      rep_d = {vote, vote, vote};
    end else if (inj_en_i) begin
      for (int r = 0; r < 3; r++) begin
        if (inj_replica_i == 2'(r)) rep_d[r] = rep_q[r] ^ inj_mask_i;
      end
    end

    // Fault flags latch on the updated count; clear overrides everything.
    for (int r = 0; r < 3; r++) begin
      if (cnt_d[r] >= Thr) fault_d[r] = 1'b1;
    end
    if (clr_i) begin
      cnt_d   = '0;
      fault_d = '0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      per_q     <= PerReload;
      rep_q     <= '0;
      mm_q      <= '0;
      cnt_q     <= '0;
      fault_q   <= '0;
      err_q     <= 1'b0;
      err_rep_q <= '0;
      multi_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      per_q     <= per_d;
      rep_q     <= rep_d;
      mm_q      <= mm_d;
      cnt_q     <= cnt_d;
      fault_q   <= fault_d;
      err_q     <= err_d;
      err_rep_q <= err_rep_d;
      multi_q   <= multi_d;
    end
  end

endmodule

// File: tb/tb_tmr_scrub_ctrl.sv
// Randomised + directed bench for tmr_scrub_ctrl. The reference model tracks
// the replicas as plain values and the scrub schedule as the absolute cycle
// of the next check; expected error pulses go into a scoreboard queue that a
// separate negedge monitor drains.
module tb_tmr_scrub_ctrl;
  localparam int DW  = 32;
  localparam int P   = 5;
  localparam int CW  = 3;
  localparam int THR = 4;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          clk = 1'b0, rst_n = 1'b1;
  logic          wr_en = 1'b0, scrub_en = 1'b0, inj_en = 1'b0, clr = 1'b0;
  logic [DW-1:0] wr_data = '0, inj_mask = '0;
  logic [1:0]    inj_sel = 2'd3;
  logic [DW-1:0] rd_data;
  logic          err, multi;
  logic [2:0]    err_rep, fault;
  logic [3*CW-1:0] err_cnt;

  always #5 clk = ~clk;

  tmr_scrub_ctrl #(.DataWidth(DW), .VoterType(2), .ScrubPeriod(P),
                   .ErrCntWidth(CW), .FaultThreshold(THR)) dut (
    .clk_i(clk), .rst_ni(rst_n), .wr_en_i(wr_en), .wr_data_i(wr_data),
    .rd_data_o(rd_data), .scrub_en_i(scrub_en), .inj_en_i(inj_en),
    .inj_replica_i(inj_sel), .inj_mask_i(inj_mask), .clr_i(clr),
    .err_o(err), .err_replica_o(err_rep), .multi_err_o(multi),
    .err_cnt_o(err_cnt), .fault_o(fault));

  typedef struct { int cyc; logic [2:0] rep; logic multi; } exp_t;
  exp_t q[$];
  exp_t mon_e;

  logic [DW-1:0] m_rep[3];
  int            m_cnt[3];
  logic [2:0]    m_fault, m_mm;
  int            cyc, check_at;
  int            total = 0, bad = 0;
  bit            mon_on = 1'b0;

  function automatic logic [DW-1:0] maj(input logic [DW-1:0] a, b, c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < 3; r++) begin m_rep[r] = '0; m_cnt[r] = 0; end
    m_fault = '0; m_mm = '0; q.delete(); cyc = 0; check_at = P;
  endtask

  // Apply one clock edge's worth of behaviour using the inputs held before it.
  task automatic model_edge();
    logic [DW-1:0] v;
    bit fix;
    v = maj(m_rep[0], m_rep[1], m_rep[2]);
    fix = 1'b0;
    if (cyc == check_at) begin
      if (wr_en) check_at = cyc + 1 + P;
      else for (int r = 0; r < 3; r++) m_mm[r] = (m_rep[r] != v);
    end else if (cyc == check_at + 1) begin
      check_at = cyc + 1 + P;
      if (!wr_en) begin
        fix = 1'b1;
        for (int r = 0; r < 3; r++) if (m_mm[r] && m_cnt[r] < CNT_MAX) m_cnt[r]++;
        if (m_mm != 0) q.push_back('{cyc + 1, m_mm, ($countones(m_mm) >= 2)});
      end
    end else if (!scrub_en) begin
      check_at = cyc + 1 + P;
    end
    if (wr_en) for (int r = 0; r < 3; r++) m_rep[r] = wr_data;
    else if (fix) for (int r = 0; r < 3; r++) m_rep[r] = v;
    else if (inj_en && inj_sel != 2'd3) m_rep[int'(inj_sel)] ^= inj_mask;
    if (clr) begin
      for (int r = 0; r < 3; r++) m_cnt[r] = 0;
      m_fault = '0;
    end else begin
      for (int r = 0; r < 3; r++) if (m_cnt[r] >= THR) m_fault[r] = 1'b1;
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
    if (rst_n) begin model_edge(); cyc++; end
  endtask

  task automatic inject(input int sel, input logic [DW-1:0] m);
    inj_en = 1'b1; inj_sel = 2'(sel); inj_mask = m; tick(); inj_en = 1'b0;
  endtask

  task automatic write(input logic [DW-1:0] d);
    wr_en = 1'b1; wr_data = d; tick(); wr_en = 1'b0;
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 50 && (cyc == check_at || cyc == check_at + 1); k++) tick();
  endtask

  // off=0: DUT is in its check cycle now; off=1: in its correct cycle.
  task automatic wait_phase(input int off);
    for (int k = 0; k < 50 && cyc != check_at + off; k++) tick();
  endtask

  task automatic do_reset();
    rst_n = 1'b0; model_reset(); tick(); tick(); rst_n = 1'b1;
  endtask

  // Monitor: compare visible state and pop expected error pulses.
  always @(negedge clk) begin
    if (mon_on) begin
      chk("rd_data", 64'(rd_data), 64'(maj(m_rep[0], m_rep[1], m_rep[2])));
      chk("err_cnt", 64'(err_cnt),
          64'({m_cnt[2][CW-1:0], m_cnt[1][CW-1:0], m_cnt[0][CW-1:0]}));
      chk("fault", 64'(fault), 64'(m_fault));
      if (q.size() > 0 && q[0].cyc == cyc && rst_n) begin
        mon_e = q.pop_front();
        chk("err_pulse", 64'(err), 64'd1);
        chk("err_replica", 64'(err_rep), 64'(mon_e.rep));
        chk("multi_err", 64'(multi), 64'(mon_e.multi));
      end else begin
        chk("err_quiet", 64'(err), 64'd0);
        chk("err_rep_quiet", 64'(err_rep), 64'd0);
        chk("multi_quiet", 64'(multi), 64'd0);
      end
    end
  end

  initial begin
    model_reset();
    #1 rst_n = 1'b0;
    mon_on = 1'b1;
    tick(); tick();
    rst_n = 1'b1;
    // Idle with scrubbing off: nothing may happen.
    repeat (100) tick();

    // Single-replica upset, then a silent follow-up scrub.
    write(32'hA5A5A5A5);
    inject(1, 32'h1);
    scrub_en = 1'b1;
    repeat (2 * (P + 2) + 3) tick();

    // Two replicas upset in different bits: vote still correct, multi error.
    wait_idle(); inject(0, 32'h1); wait_idle(); inject(2, 32'h2);
    repeat (P + 4) tick();

    // Repeated faults on replica 2 reach the threshold; flag is sticky until clear.
    for (int i = 0; i < 4; i++) begin
      wait_idle(); inject(2, 32'h1 << i); wait_phase(1); tick();
    end
    repeat (2 * (P + 2)) tick();
    clr = 1'b1; tick(); clr = 1'b0;
    repeat (3) tick();

    // Host write during CHECK aborts, then during CORRECT aborts.
    wait_idle(); inject(0, 32'h10);
    wait_phase(0); write(32'h12345678);
    repeat (P + 4) tick();
    wait_idle(); inject(1, 32'h4);
    wait_phase(1); write(32'hCAFEF00D);
    repeat (P + 4) tick();

    // Counter saturation on replica 1, then clear in a CORRECT with a mismatch.
    for (int i = 0; i < CNT_MAX + 2; i++) begin
      wait_idle(); inject(1, 32'h100 << (i % 8)); wait_phase(1); tick();
    end
    wait_idle(); inject(1, 32'h8000_0000); wait_phase(1);
    clr = 1'b1; tick(); clr = 1'b0;
    repeat (3) tick();

    // Dropping scrub_en inside a scrub does not abort it; in IDLE it restarts the period.
    wait_idle(); inject(0, 32'h3); wait_phase(0);
    scrub_en = 1'b0; tick(); tick(); repeat (3) tick();
    scrub_en = 1'b1; repeat (P + 4) tick();

    // Reset in the middle of a mismatching scrub: no pulse, all state cleared.
    wait_idle(); inject(2, 32'hF0); wait_phase(1);
    do_reset();
    scrub_en = 1'b1;
    repeat (P + 3) tick();

    // Random traffic.
    for (int i = 0; i < 2000; i++) begin
      wr_en    = ($urandom_range(0, 99) < 4);
      wr_data  = $urandom;
      inj_en   = ($urandom_range(0, 99) < 35);
      inj_sel  = 2'($urandom_range(0, 3));
      inj_mask = ($urandom_range(0, 1) == 1) ? $urandom : (32'h1 << $urandom_range(0, 31));
      scrub_en = ($urandom_range(0, 99) < 92);
      clr      = ($urandom_range(0, 99) < 2);
      tick();
    end
    wr_en = 1'b0; inj_en = 1'b0; clr = 1'b0; scrub_en = 1'b1;
    repeat (2 * (P + 2)) tick();

    mon_on = 1'b0;
    chk("scoreboard_drained", 64'(q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
